riscv_fetch_queue: RTL and testbench

//  Parametrised IF stage for the pipelined RISC-V core: owns the fetch PC, drives the I-cache, converts big-endian cache words to little-endian instructions,
//  and buffers them in a DEPTH-entry queue. The queue decouples fetch from ID stalls; ID pops {pc, pc+4, instr} through a valid/ready handshake.

---
 rtl/riscv_fetch_queue_pkg.sv | 32 +++
 rtl/riscv_fetch_queue_if.sv | 38 +++
 rtl/riscv_fetch_queue_fifo.sv | 70 +++++++
 rtl/riscv_fetch_queue.sv | 125 ++++++++++++
 tb/tb_riscv_fetch_queue.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_fetch_queue_pkg.sv
// rtl/riscv_fetch_queue_pkg.sv - shared types, constants and helpers for the fetch queue
// Purpose: default data width, JAL opcode, byte-swap and J-immediate helpers,
//          FSM state type and the queue entry layout.
// Ports:   none (package).
package riscv_fetch_queue_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam logic [6:0]  OPC_JAL  = 7'b1101111;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_REDIR = 1'b1
   } state_e;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] pc_plus;
      logic [31:0]         instr;
      logic                pred_taken;
   } fetch_entry_t;

   // I-cache words arrive big-endian; the core wants little-endian instructions.
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // J-type immediate: imm[20|10:1|11|19:12], sign-extended, bit 0 always zero.
   function automatic logic [XLEN_DEF-1:0] jimm(input logic [31:0] instr);
      return {{(XLEN_DEF-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/riscv_fetch_queue_if.sv
// rtl/riscv_fetch_queue_if.sv - I-cache and ID-stage signal bundle for the fetch queue
// Purpose: groups the I-cache request/response and the ID valid/ready handshake.
// Ports:   master = fetch queue side, slave = cache/ID environment side.
interface riscv_fetch_queue_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 30
);
   logic              icache_ren;
   logic              icache_wen;
   logic [ADDR_W-1:0] icache_addr;
   logic [XLEN-1:0]   icache_wdata;
   logic              icache_stall;
   logic [XLEN-1:0]   icache_rdata;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              id_ready;
   logic              id_valid;
   logic [31:0]       id_instr;
   logic [XLEN-1:0]   id_pc;
   logic [XLEN-1:0]   id_pc_plus;
   logic              id_pred_taken;

   modport master (
      output icache_ren, icache_wen, icache_addr, icache_wdata,
      input  icache_stall, icache_rdata,
      input  redirect_valid, redirect_pc,
      input  id_ready,
      output id_valid, id_instr, id_pc, id_pc_plus, id_pred_taken
   );

   modport slave (
      input  icache_ren, icache_wen, icache_addr, icache_wdata,
      output icache_stall, icache_rdata,
      output redirect_valid, redirect_pc,
      output id_ready,
      input  id_valid, id_instr, id_pc, id_pc_plus, id_pred_taken
   );
endinterface

// File: rtl/riscv_fetch_queue_fifo.sv
// rtl/riscv_fetch_queue_fifo.sv - synchronous FIFO with flush and registered head data
// Purpose: DEPTH-entry queue; the head entry is held in a register so readers never
//          see a combinational path from the write side.
// Ports:   clk, rst (sync, active-high), push/wdata, pop, flush,
//          rdata (head), full, empty, count.
module riscv_fetch_queue_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             push_ok, pop_ok;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign count   = wr_ptr_q - rd_ptr_q;
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = rdata_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop_ok};
      rdata_d  = rdata_q;
      // If the new head slot is the one being written now, take the write data.
      if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
         rdata_d = wdata;
      end else if (pop_ok) begin
         rdata_d = mem_q[rd_ptr_d[PTR_W-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rdata_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rdata_q  <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush && !rst) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/riscv_fetch_queue.sv
// rtl/riscv_fetch_queue.sv - IF stage: fetch PC, I-cache request, instruction queue to ID
// Purpose: owns the fetch PC, requests words from the I-cache, byte-swaps them and
//          buffers {pc, pc+4, instr, pred_taken} for ID; handles redirects, including
//          a redirect that lands while a cache request is stalled.
// Ports:   clk, rst (sync, active-high), bus (riscv_fetch_queue_if.master), pc_o.
// Config:  STATIC_JAL_PREDICT_EN - follow JAL targets at fetch and mark entries taken.
module riscv_fetch_queue
   import riscv_fetch_queue_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter int unsigned     ADDR_W   = XLEN - 2,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   riscv_fetch_queue_if.master   bus,
   output logic [XLEN-1:0]       pc_o
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
   logic [XLEN-1:0]   seq_pc;
   logic [31:0]       instr_sw;
   logic              is_pred;
   logic              fetch_done;
   logic              fifo_push, fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   fetch_entry_t      push_entry, head_entry;

   // Request uses the registered count: a same-cycle pop does not open a slot.
   assign bus.icache_ren   = ~rst & (fifo_count < CNT_W'(DEPTH));
   assign bus.icache_wen   = 1'b0;
   assign bus.icache_wdata = '0;
   assign bus.icache_addr  = fetch_pc_q[XLEN-1:2];
   assign fetch_done       = bus.icache_ren & ~bus.icache_stall;
   assign instr_sw         = bswap32(bus.icache_rdata);
   assign pc_o             = fetch_pc_q;

`ifdef STATIC_JAL_PREDICT_EN
   assign is_pred = (instr_sw[6:0] == OPC_JAL);
   assign seq_pc  = fetch_pc_q + (is_pred ? jimm(instr_sw) : XLEN'(4));
`else
   assign is_pred = 1'b0;
   assign seq_pc  = fetch_pc_q + XLEN'(4);
`endif

   always_comb begin
      push_entry.pc         = fetch_pc_q;
      push_entry.pc_plus    = fetch_pc_q + XLEN'(4);
      push_entry.instr      = instr_sw;
      push_entry.pred_taken = is_pred;
   end

   // Redirect wins over push; in REDIR the completing response is dropped.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pend_pc_d  = pend_pc_q;
      fifo_push  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (bus.redirect_valid) begin
               if (bus.icache_ren && bus.icache_stall) begin
                  // Address must stay put until the stalled word returns.
                  pend_pc_d = bus.redirect_pc;
                  state_d   = ST_REDIR;
               end else begin
                  fetch_pc_d = bus.redirect_pc;
               end
            end else if (fetch_done && !fifo_full) begin
               fifo_push  = 1'b1;
               fetch_pc_d = seq_pc;
            end
         end
         ST_REDIR: begin
            if (bus.redirect_valid) begin
               pend_pc_d = bus.redirect_pc;
            end
            if (fetch_done) begin
               fetch_pc_d = bus.redirect_valid ? bus.redirect_pc : pend_pc_q;
               state_d    = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_PC;
         pend_pc_q  <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pend_pc_q  <= pend_pc_d;
      end
   end

   riscv_fetch_queue_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (push_entry),
      .pop   (bus.id_ready),
      .flush (bus.redirect_valid),
      .rdata (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.id_valid      = ~fifo_empty;
   assign bus.id_instr      = head_entry.instr;
   assign bus.id_pc         = head_entry.pc;
   assign bus.id_pc_plus    = head_entry.pc_plus;
   assign bus.id_pred_taken = head_entry.pred_taken;

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb/tb_riscv_fetch_queue.sv - scoreboard bench for riscv_fetch_queue
module tb_riscv_fetch_queue;
   import riscv_fetch_queue_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_o;

   always #5 clk = ~clk;

   riscv_fetch_queue_if #(.XLEN(32), .ADDR_W(30)) bus ();

   riscv_fetch_queue #(
      .XLEN     (32),
      .ADDR_W   (30),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .pc_o (pc_o)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pcp;
      logic [31:0] instr;
      logic        pred;
   } exp_t;

   exp_t        sb[$];
   exp_t        n_entry;
   logic [31:0] m_pc = 0, m_pend = 0, n_pc = 0, n_pend = 0;
   logic        m_discard = 0, n_discard = 0, n_flush = 0, n_push = 0;
   logic        cur_ren = 0;
   logic        mon_en = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   function automatic logic [31:0] swap_ref(input logic [31:0] w);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] jimm_ref(input logic [31:0] i);
      int v;
      v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096;
      if (i[31]) v = v - (1 << 20);
      return 32'(v);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One cycle: commit the model effects of the edge just taken, then drive
   // the next inputs and work out what the coming edge should do.
   task automatic step(input logic r, input logic st, input logic rv, input logic [31:0] rpc,
                       input logic [31:0] rd, input logic rdy);
      logic [31:0] ins;
      logic        done, jal;
      @(posedge clk);
      if (n_flush) sb.delete();
      if (n_push) sb.push_back(n_entry);
      m_pc = n_pc; m_pend = n_pend; m_discard = n_discard;
      #1;
      rst = r;
      bus.icache_stall = st; bus.redirect_valid = rv; bus.redirect_pc = rpc;
      bus.icache_rdata = rd; bus.id_ready = rdy;
      cur_ren = !r && (sb.size() < DEPTH);
      done = cur_ren && !st;
      ins = swap_ref(rd);
`ifdef STATIC_JAL_PREDICT_EN
      jal = (ins[6:0] == 7'h6F);
`else
      jal = 1'b0;
`endif
      n_flush = 0; n_push = 0; n_pc = m_pc; n_pend = m_pend; n_discard = m_discard;
      if (r) begin
         n_flush = 1; n_pc = 0; n_discard = 0;
      end else if (m_discard) begin
         if (rv) begin n_pend = rpc; n_flush = 1; end
         if (done) begin n_pc = n_pend; n_discard = 0; end
      end else if (rv) begin
         n_flush = 1;
         if (cur_ren && st) begin n_pend = rpc; n_discard = 1; end
         else n_pc = rpc;
      end else if (done) begin
         n_push = 1;
         n_entry = '{m_pc, m_pc + 4, ins, jal};
         n_pc = jal ? m_pc + jimm_ref(ins) : m_pc + 4;
      end
   endtask

   // Monitor: compares DUT outputs against the scoreboard and retires on handshake.
   always @(negedge clk) begin
      if (mon_en) begin
         check("ren", 128'(bus.icache_ren), 128'(cur_ren));
         check("addr", 128'(bus.icache_addr), 128'(m_pc[31:2]));
         check("pc_o", 128'(pc_o), 128'(m_pc));
         check("id_valid", 128'(bus.id_valid), 128'(sb.size() != 0));
         if (bus.id_valid && sb.size() != 0) begin
            check("head", {bus.id_pc, bus.id_pc_plus, bus.id_instr, bus.id_pred_taken},
                  {sb[0].pc, sb[0].pcp, sb[0].instr, sb[0].pred});
            if (bus.id_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] r, w;
      bus.icache_stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
      bus.icache_rdata = 0; bus.id_ready = 0;

      // Reset and sequential fetch of NOPs
      step(1, 0, 0, 0, 32'h13000000, 1);
      mon_en = 1;
      check("rst_pred", 128'(bus.id_pred_taken), 128'(0));
      step(1, 0, 0, 0, 32'h13000000, 1);
      repeat (6) step(0, 0, 0, 0, 32'h13000000, 1);

      // Fill to DEPTH with ID stalled, then single pop
      repeat (7) step(0, 0, 0, 0, 32'h13000000, 0);
      step(0, 0, 0, 0, 32'h13000000, 1);
      repeat (3) step(0, 0, 0, 0, 32'h13000000, 0);

      // Stall at pc 0x10
      step(0, 0, 1, 32'h10, 0, 1);
      repeat (3) step(0, 1, 0, 0, 32'h93000000, 1);
      repeat (3) step(0, 0, 0, 0, 32'h93000000, 0);

      // Redirect with queued entries
      step(0, 0, 1, 32'h100, 0, 0);
      repeat (3) step(0, 0, 0, 0, 32'h13000000, 1);

      // Redirect while stalled: stalled word is discarded
      step(0, 0, 1, 32'h20, 0, 1);
      step(0, 1, 0, 0, 0, 1);
      step(0, 1, 1, 32'h200, 32'hDEADBEEF, 1);
      step(0, 0, 0, 0, 32'hDEADBEEF, 1);
      repeat (3) step(0, 0, 0, 0, 32'h13000000, 1);

      // JAL +0x40 at pc 0x8
      step(0, 0, 1, 32'h8, 0, 0);
      step(0, 0, 0, 0, 32'h6F000004, 0);
      step(0, 1, 0, 0, 0, 0);
`ifdef STATIC_JAL_PREDICT_EN
      check("jal_pc", 128'(pc_o), 128'(32'h48));
      check("jal_pred", 128'(bus.id_pred_taken), 128'(1));
`else
      check("jal_pc", 128'(pc_o), 128'(32'hC));
      check("jal_pred", 128'(bus.id_pred_taken), 128'(0));
`endif
      check("jal_link", 128'(bus.id_pc_plus), 128'(32'hC));

      // Reset in the middle of a stall
      step(0, 1, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0, 32'h13000000, 1);

      // Randomised traffic
      for (int c = 0; c < 2000; c++) begin
         r = $urandom();
         if ($urandom_range(0, 5) == 0) begin
            w = {r[31:12], r[11:7], 7'b1101111};
            w = swap_ref(w);
         end else begin
            w = $urandom();
         end
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 9) < 3,
              $urandom_range(0, 11) == 0,
              32'($urandom_range(0, 255)) * 4,
              w,
              $urandom_range(0, 9) < 6);
      end

      @(posedge clk);
      mon_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
